german_rule_scheduler: RTL
==========================

// Module: german_rule_scheduler
// PURPOSE
//  Rule scheduler for the German-protocol `system` model. Each cycle it takes the
//  per-rule guard vector and picks one enabled rule. It drives the rule index onto
//  the system's io_en_a, so one protocol rule fires per clock.
//  It sits between the guard-evaluation logic and `system`.
//  Modes: round-robin (exhaustive) or LFSR pseudo-random (with anti-starvation).
//  It also detects deadlock and counts fired rules.
// PARAMETERS
//  NUM_RULES    20       number of protocol rules; valid indices 0..NUM_RULES-1
//  RULE_W       5        width of io_en_a; 2**(RULE_W-1) < NUM_RULES <= 2**RULE_W-1
//  IDLE_CODE    5'h1F    io_en_a value meaning "no rule"; `system` treats it as a no-op
//  LFSR_SEED    16'hACE1 reset value of the 16-bit Galois LFSR (taps 16,14,13,11); must be nonzero
//  STARVE_MAX   15       consecutive LFSR grants before one forced round-robin grant
//  DEAD_CYC     8        consecutive cycles with zero guards before declaring deadlock
// PORTS
//  clock           in   1          rising-edge clock
//  reset           in   1          asynchronous, active-low reset
//  io_guard        in   NUM_RULES  bit i = rule i enabled in current state
//  io_mode         in   1          0 = round-robin, 1 = LFSR
//  io_run          in   1          1 = free-run; 0 = fire only on io_step
//  io_step         in   1          single-shot fire request (used when io_run=0)
//  io_en_a         out  RULE_W     selected rule index, registered; IDLE_CODE when none
//  io_fire         out  1          io_en_a holds a real rule this cycle
//  io_deadlock     out  1          sticky deadlock flag
//  io_fire_count   out  32         rules fired since reset; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (async, while reset=0):
//   - io_en_a=IDLE_CODE, io_fire=0, io_deadlock=0, io_fire_count=0.
//   - rr_ptr=NUM_RULES-1, lfsr=LFSR_SEED, starve=0, dead=0, FSM=IDLE.
//  FSM states:
//   - IDLE: leave on io_run=1 or io_step=1 and go to ARB.
//   - ARB: on each cycle with a request (io_run=1, or io_step pulse) and any guard set:
//     register the grant. If io_run=0, return to IDLE after one grant.
//   - DEAD: entered when dead reaches DEAD_CYC. Sets io_deadlock=1; io_fire=0.
//     Leaves only via reset, or io_run=0 with io_step=0 (then go to IDLE and clear io_deadlock).
//  Latency: guard sampled at edge N, so io_en_a/io_fire are valid after edge N, for cycle N+1.
//   io_en_a reverts to IDLE_CODE the cycle after any non-grant.
//  Round-robin: grant the first set guard at index rr_ptr+1, rr_ptr+2, ..., wrapping from
//   NUM_RULES-1 to 0. rr_ptr <= granted index. A single set guard equal to rr_ptr is re-granted.
//  LFSR:
//   - start = lfsr[RULE_W-1:0]; if start >= NUM_RULES, then start -= NUM_RULES.
//   - Grant the first set guard at index >= start, with wrap-around.
//   - The LFSR advances every granting cycle only.
//   - starve++ per LFSR grant. When starve==STARVE_MAX, the next grant uses the round-robin
//     rule instead and clears starve. rr_ptr updates on every grant, in either mode.
//  Mode change: takes effect on the next grant. starve clears when io_mode=0.
//  Deadlock counter: dead++ (saturating) while requesting with io_guard==0; dead clears on any grant.
//  io_fire_count: +1 per cycle with io_fire=1; saturating.
//  io_step while io_run=1 is ignored. An io_step asserted on the same cycle it is granted is
//   consumed; holding io_step high gives one grant every 2 cycles (ARB->IDLE->ARB).
//  Reset mid-grant: outputs return to reset values immediately. No partial state survives.
// STRUCTURE
//  Shared package german_pkg:
//   - localparams NUM_RULES, RULE_W, IDLE_CODE.
//   - enum sched_state_e {IDLE, ARB, DEAD}.
//   - LFSR tap mask.
//  Sub-module rr_find_first: combinational masked priority encoder with wrap-around.
//   Inputs: vec[NUM_RULES], start[RULE_W]. Outputs: idx, found.
//   Instantiated once; its start input is muxed between the RR pointer and the LFSR start.
// TESTING
//  1. Reset, io_run=0, io_step=0, guards=all-ones -> io_en_a=5'h1F, io_fire=0, count=0 for 10 cycles.
//  2. RR, io_run=1, guards=20'h00015 (rules 0,2,4) -> io_en_a sequence 0,2,4,0,2,4; count=6 after 6 grants.
//  3. RR wrap: guards={rule19, rule0}, rr_ptr=18 -> grants 19 then 0. Single guard rule 7 -> 7 every cycle.
//  4. LFSR, guards all-ones, seed 16'hACE1 -> grant sequence matches the golden model.
//     16th grant equals (rr_ptr+1) mod 20 (STARVE_MAX forced).
//  5. io_run=1, guards=0 for 8 cycles -> io_deadlock=1 from cycle 9.
//     Guards return -> still deadlocked. io_run=0 -> IDLE, flag clears.
//  6. Step mode: io_run=0, three io_step pulses with guards=20'h00008 -> exactly 3 fires of index 3.
//     Reset asserted mid-run -> outputs reset asynchronously, same cycle.

Source files
------------

// File: rtl/german_pkg.sv
// Shared types and constants for the German-protocol rule scheduler.
// Rule count, encoding widths, LFSR taps and the scheduler state enum live here.
package german_pkg;

    localparam int              NUM_RULES  = 20;
    localparam int              RULE_W     = 5;
    localparam logic [4:0]      IDLE_CODE  = 5'h1F;
    localparam logic [4:0]      LAST_RULE  = 5'd19;
    localparam logic [4:0]      NUM_RULES_W = 5'd20;
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
    // Galois right-shift form of taps 16,14,13,11
    localparam logic [15:0]     LFSR_TAPS  = 16'hB400;
    localparam logic [3:0]      STARVE_MAX = 4'd15;
    localparam logic [3:0]      DEAD_CYC   = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DEAD = 2'd2
    } sched_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/german_rule_scheduler_rr_find_first.sv
// Wrap-around priority encoder: first set bit of vec at index >= start,
// continuing from 0 after the last rule. start must be below NUM_RULES.
module rr_find_first
    import german_pkg::*;
(
    input  logic [NUM_RULES-1:0] vec,
    input  logic [RULE_W-1:0]    start,
    output logic [RULE_W-1:0]    idx,
    output logic                 found
);

    logic [RULE_W:0] pos_s;

    // Scan all rules from start with wrap; the first hit wins.
    always_comb begin
        idx   = {RULE_W{1'b0}};
        found = 1'b0;
        pos_s = {(RULE_W+1){1'b0}};
        for (int k = 0; k < NUM_RULES; k++) begin
            pos_s = {1'b0, start} + 6'(k);
            if (pos_s >= 6'(NUM_RULES)) begin
                pos_s = pos_s - 6'(NUM_RULES);
            end else begin
                pos_s = pos_s;
            end
            if (!found && vec[pos_s[RULE_W-1:0]]) begin
                found = 1'b1;
                idx   = pos_s[RULE_W-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/german_rule_scheduler.sv
// Picks one enabled protocol rule per clock (round-robin or LFSR with
// anti-starvation), flags deadlock and counts fired rules.
module german_rule_scheduler
    import german_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_RULES-1:0] io_guard,
    input  logic                 io_mode,
    input  logic                 io_run,
    input  logic                 io_step,
    output logic [RULE_W-1:0]    io_en_a,
    output logic                 io_fire,
    output logic                 io_deadlock,
    output logic [31:0]          io_fire_count
);

    sched_state_e      state_q, state_d;
    logic [RULE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [3:0]        starve_q, starve_d;
    logic [3:0]        dead_q, dead_d;
    logic [RULE_W-1:0] en_a_q, en_a_d;
    logic              fire_q, fire_d;
    logic              deadlock_q, deadlock_d;
    logic [31:0]       count_q, count_d;

    logic              req_s;
    logic              any_s;
    logic              use_rr_s;
    logic [RULE_W-1:0] rr_start_s;
    logic [RULE_W-1:0] lfsr_raw_s;
    logic [RULE_W-1:0] lfsr_start_s;
    logic [RULE_W-1:0] start_s;
    logic [RULE_W-1:0] pick_idx_s;
    logic              pick_found_s;
    logic [3:0]        dead_inc_s;
    logic              dead_hit_s;

    assign req_s        = io_run | io_step;
    assign any_s        = |io_guard;
    // A forced round-robin grant breaks a long LFSR streak.
    assign use_rr_s     = !io_mode || (starve_q == STARVE_MAX);
    assign rr_start_s   = (rr_ptr_q == LAST_RULE) ? 5'd0 : rr_ptr_q + 5'd1;
    assign lfsr_raw_s   = lfsr_q[RULE_W-1:0];
    assign lfsr_start_s = (lfsr_raw_s >= NUM_RULES_W) ? lfsr_raw_s - NUM_RULES_W : lfsr_raw_s;
    assign start_s      = use_rr_s ? rr_start_s : lfsr_start_s;
    assign dead_inc_s   = (dead_q == 4'hF) ? dead_q : dead_q + 4'd1;
    assign dead_hit_s   = (dead_inc_s == DEAD_CYC);

    rr_find_first u_find (
        .vec   (io_guard),
        .start (start_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Next-state, grant selection and output computation.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lfsr_d     = lfsr_q;
        starve_d   = io_mode ? starve_q : 4'd0;
        dead_d     = dead_q;
        en_a_d     = IDLE_CODE;
        fire_d     = 1'b0;
        deadlock_d = deadlock_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (req_s && !any_s) begin
                    dead_d     = dead_inc_s;
                    state_d    = dead_hit_s ? DEAD : ARB;
                    deadlock_d = dead_hit_s;
                end else if (req_s) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                if (req_s && pick_found_s) begin
                    state_d  = io_run ? ARB : IDLE;
                    en_a_d   = pick_idx_s;
                    fire_d   = 1'b1;
                    rr_ptr_d = pick_idx_s;
                    lfsr_d   = lfsr_next(lfsr_q);
                    dead_d   = 4'd0;
                    count_d  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                    if (io_mode) begin
                        starve_d = (starve_q == STARVE_MAX) ? 4'd0 : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (req_s) begin
                    dead_d     = dead_inc_s;
                    state_d    = dead_hit_s ? DEAD : ARB;
                    deadlock_d = dead_hit_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DEAD: begin
                if (!io_run && !io_step) begin
                    state_d    = IDLE;
                    deadlock_d = 1'b0;
                    dead_d     = 4'd0;
                end else begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= LAST_RULE;
            lfsr_q     <= LFSR_SEED;
            starve_q   <= 4'd0;
            dead_q     <= 4'd0;
            en_a_q     <= IDLE_CODE;
            fire_q     <= 1'b0;
            deadlock_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lfsr_q     <= lfsr_d;
            starve_q   <= starve_d;
            dead_q     <= dead_d;
            en_a_q     <= en_a_d;
            fire_q     <= fire_d;
            deadlock_q <= deadlock_d;
            count_q    <= count_d;
        end
    end

    assign io_en_a       = en_a_q;
    assign io_fire       = fire_q;
    assign io_deadlock   = deadlock_q;
    assign io_fire_count = count_q;

endmodule
